vball_rom_arb: RTL and testbench

- Shares the single external byte-wide graphics/sample ROM port among three requesters:
  - background tile fetcher (bg)
  - sprite pixel fetcher (spr)
  - ADPCM sample fetcher (snd)
- Sits between the video/sound engines and the SDRAM ROM channel in the vball top level.
- Adds a per-requester base offset, serialises accesses, and prevents sound starvation.
- Guards against a hung memory with a timeout.

---
 rtl/vball_pkg.sv | 27 ++
 rtl/vball_rom_arb_if.sv | 44 ++++
 rtl/vball_rr_pri.sv | 26 ++
 rtl/vball_rom_arb.sv | 138 +++++++++++++
 tb/tb_vball_rom_arb.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vball_pkg.sv
// Shared types and constants for the vball ROM port arbiter and its requesters.
package vball_pkg;

    // Requester identity; the values double as bit positions in one-hot grants.
    typedef enum logic [1:0] {
        GNT_BG  = 2'd0,
        GNT_SPR = 2'd1,
        GNT_SND = 2'd2
    } gnt_id_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int BG_AW  = 19;
    localparam int SPR_AW = 17;
    localparam int SND_AW = 17;
    localparam int DATA_W = 8;

    // Region offsets; these must match the ROM loader's download map.
    localparam logic [21:0] DEF_BG_BASE  = 22'h000000;
    localparam logic [21:0] DEF_SPR_BASE = 22'h080000;
    localparam logic [21:0] DEF_SND_BASE = 22'h0C0000;

endpackage

// File: rtl/vball_rom_arb_if.sv
// Bundle of requester handshakes and the external ROM channel.
// slave is the arbiter's view; master is the view of the engines and memory.
interface vball_rom_arb_if
    import vball_pkg::*;
#(
    parameter int MEM_AW = 22
);
    logic              bg_req;
    logic [BG_AW-1:0]  bg_addr;
    logic              bg_ack;
    logic [DATA_W-1:0] bg_data;

    logic              spr_req;
    logic [SPR_AW-1:0] spr_addr;
    logic              spr_ack;
    logic [DATA_W-1:0] spr_data;

    logic              snd_req;
    logic [SND_AW-1:0] snd_addr;
    logic              snd_ack;
    logic [DATA_W-1:0] snd_data;

    logic              mem_req;
    logic [MEM_AW-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_rdy;

    logic              err;

    modport slave (
        input  bg_req, bg_addr, spr_req, spr_addr, snd_req, snd_addr,
        input  mem_data, mem_rdy,
        output bg_ack, bg_data, spr_ack, spr_data, snd_ack, snd_data,
        output mem_req, mem_addr, err
    );

    modport master (
        output bg_req, bg_addr, spr_req, spr_addr, snd_req, snd_addr,
        output mem_data, mem_rdy,
        input  bg_ack, bg_data, spr_ack, spr_data, snd_ack, snd_data,
        input  mem_req, mem_addr, err
    );

endinterface

// File: rtl/vball_rr_pri.sv
// Fixed-priority picker (bg > spr > snd) where a starved snd jumps the queue.
module vball_rr_pri
    import vball_pkg::*;
(
    input  logic       bg_req_i,
    input  logic       spr_req_i,
    input  logic       snd_req_i,
    input  logic       starve_i,
    output logic [2:0] gnt_o
);

    // Choose at most one requester, one-hot indexed by gnt_id_t.
    always_comb begin
        gnt_o = 3'b000;
        if (starve_i && snd_req_i) begin
            gnt_o[GNT_SND] = 1'b1;
        end else if (bg_req_i) begin
            gnt_o[GNT_BG] = 1'b1;
        end else if (spr_req_i) begin
            gnt_o[GNT_SPR] = 1'b1;
        end else if (snd_req_i) begin
            gnt_o[GNT_SND] = 1'b1;
        end
    end

endmodule

// File: rtl/vball_rom_arb.sv
// Serialises bg/sprite/sample reads onto the single byte-wide ROM channel,
// adds each requester's region base, and aborts accesses on a hung memory.
module vball_rom_arb
    import vball_pkg::*;
#(
    parameter int                MEM_AW     = 22,
    parameter logic [MEM_AW-1:0] BG_BASE    = MEM_AW'(DEF_BG_BASE),
    parameter logic [MEM_AW-1:0] SPR_BASE   = MEM_AW'(DEF_SPR_BASE),
    parameter logic [MEM_AW-1:0] SND_BASE   = MEM_AW'(DEF_SND_BASE),
    parameter int                STARVE_MAX = 15,
    parameter int                TIMEOUT    = 63
) (
    input logic            clk_sys,
    input logic            reset_n,
    vball_rom_arb_if.slave bus
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [7:0] TIMER_LIM  = 8'(TIMEOUT);

    state_t            state_q;
    gnt_id_t           gnt_q;
    logic              mem_req_q;
    logic [MEM_AW-1:0] mem_addr_q;
    logic [7:0]        timer_q;
    logic [3:0]        starve_q;
    logic              err_q;
    logic              bg_ack_q, spr_ack_q, snd_ack_q;
    logic [DATA_W-1:0] bg_data_q, spr_data_q, snd_data_q;

    logic [2:0]        pick_oh;
    logic              starve_hit;
    gnt_id_t           pick_id_d;
    logic [MEM_AW-1:0] addr_d;
    logic [DATA_W-1:0] fill_d;

    assign starve_hit = (starve_q == STARVE_LIM);

    vball_rr_pri u_pri (
        .bg_req_i  (bus.bg_req),
        .spr_req_i (bus.spr_req),
        .snd_req_i (bus.snd_req),
        .starve_i  (starve_hit),
        .gnt_o     (pick_oh)
    );

    // Translate the one-hot pick into an id and its rebased, wrapping address;
    // an aborted access returns 8'hFF instead of bus data.
    always_comb begin
        pick_id_d = GNT_BG;
        addr_d    = BG_BASE + MEM_AW'(bus.bg_addr);
        if (pick_oh[GNT_SPR]) begin
            pick_id_d = GNT_SPR;
            addr_d    = SPR_BASE + MEM_AW'(bus.spr_addr);
        end else if (pick_oh[GNT_SND]) begin
            pick_id_d = GNT_SND;
            addr_d    = SND_BASE + MEM_AW'(bus.snd_addr);
        end
        fill_d = bus.mem_rdy ? bus.mem_data : 8'hFF;
    end

    // Access sequencer: grant in IDLE, hold the strobe in WAIT, pulse ack in DONE.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            gnt_q      <= GNT_BG;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            timer_q    <= 8'd0;
            starve_q   <= 4'd0;
            err_q      <= 1'b0;
            bg_ack_q   <= 1'b0;
            spr_ack_q  <= 1'b0;
            snd_ack_q  <= 1'b0;
            bg_data_q  <= 8'h00;
            spr_data_q <= 8'h00;
            snd_data_q <= 8'h00;
        end else begin
            bg_ack_q  <= 1'b0;
            spr_ack_q <= 1'b0;
            snd_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|pick_oh) begin
                        gnt_q      <= pick_id_d;
                        mem_addr_q <= addr_d;
                        mem_req_q  <= 1'b1;
                        timer_q    <= 8'd1;
                        state_q    <= WAIT;
                        if (pick_id_d == GNT_SND) begin
                            starve_q <= 4'd0;
                        end else if (bus.snd_req && !starve_hit) begin
                            starve_q <= starve_q + 4'd1;
                        end
                    end
                end
                WAIT: begin
                    if (bus.mem_rdy || timer_q == TIMER_LIM) begin
                        mem_req_q <= 1'b0;
                        state_q   <= DONE;
                        if (!bus.mem_rdy) begin
                            err_q <= 1'b1;
                        end
                        case (gnt_q)
                            GNT_SPR: begin
                                spr_data_q <= fill_d;
                                spr_ack_q  <= 1'b1;
                            end
                            GNT_SND: begin
                                snd_data_q <= fill_d;
                                snd_ack_q  <= 1'b1;
                            end
                            default: begin
                                bg_data_q <= fill_d;
                                bg_ack_q  <= 1'b1;
                            end
                        endcase
                    end else begin
                        timer_q <= timer_q + 8'd1;
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.mem_req  = mem_req_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.err      = err_q;
    assign bus.bg_ack   = bg_ack_q;
    assign bus.spr_ack  = spr_ack_q;
    assign bus.snd_ack  = snd_ack_q;
    assign bus.bg_data  = bg_data_q;
    assign bus.spr_data = spr_data_q;
    assign bus.snd_data = snd_data_q;

endmodule

// File: tb/tb_vball_rom_arb.sv
// Randomised bench for vball_rom_arb: requester and memory models drive the
// DUT while a transaction-level reference predicts grants, addresses and data.
module tb_vball_rom_arb;

    localparam int TB_TIMEOUT = 63;
    localparam int TB_STARVE  = 15;
    localparam logic [21:0] BASES [3] = '{22'h000000, 22'h080000, 22'h0C0000};
    localparam logic [18:0] MASKS [3] = '{19'h7FFFF, 19'h1FFFF, 19'h1FFFF};

    logic clk_sys;
    logic reset_n;

    vball_rom_arb_if #(.MEM_AW(22)) bus ();
    vball_rom_arb_if #(.MEM_AW(22)) bus2 ();

    vball_rom_arb #(.MEM_AW(22)) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Second instance with a base near the top of the space to exercise wrap.
    vball_rom_arb #(.MEM_AW(22), .SND_BASE(22'h3FFFF0)) dut_wrap (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .bus     (bus2)
    );

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    int totalChecks = 0;
    int badChecks   = 0;

    // Requester model
    bit          pend [3];
    bit          prevReq [3];
    logic [18:0] reqAddr [3];
    int          pct [3];

    // Reference state
    int          starve;
    bit          errM;
    logic [7:0]  dataM [3];
    bit          inAccess;
    bit          lastWasAck;
    int          winner;
    logic [21:0] expAddr;
    int          waitCnt;
    int          delay;
    logic [7:0]  rdData;
    bit          allowLong;
    bit          forceValid;
    int          forceDelay;
    logic [7:0]  forceData;
    int          decisionCount;
    int          sndIdx;
    logic [21:0] addrLog [$];
    logic [2:0]  ackLog [$];

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic int pickWinner();
        if (starve == TB_STARVE && prevReq[2]) return 2;
        if (prevReq[0]) return 0;
        if (prevReq[1]) return 1;
        return 2;
    endfunction

    function automatic int randomDelay();
        int r;
        r = int'($urandom_range(99));
        if (allowLong && r < 3) return 0;
        if (allowLong && r < 6) return TB_TIMEOUT;
        return int'($urandom_range(4, 1));
    endfunction

    task automatic driveReqs();
        bus.bg_req   = pend[0];
        bus.spr_req  = pend[1];
        bus.snd_req  = pend[2];
        bus.bg_addr  = (inAccess && winner == 0) ? 19'($urandom) : reqAddr[0];
        bus.spr_addr = (inAccess && winner == 1) ? 17'($urandom) : reqAddr[1][16:0];
        bus.snd_addr = (inAccess && winner == 2) ? 17'($urandom) : reqAddr[2][16:0];
        for (int i = 0; i < 3; i++) prevReq[i] = pend[i];
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < 3; i++) begin
            if (!pend[i] && int'($urandom_range(99)) < pct[i]) begin
                pend[i]    = 1'b1;
                reqAddr[i] = 19'($urandom) & MASKS[i];
            end
        end
        driveReqs();
    endtask

    task automatic monitorStep();
        logic [2:0] ackVec;
        bit         anyPrev;
        bit         expStart;
        bit         timedOut;
        ackVec  = {bus.snd_ack, bus.spr_ack, bus.bg_ack};
        anyPrev = prevReq[0] | prevReq[1] | prevReq[2];
        if (!inAccess) begin
            expStart   = anyPrev && !lastWasAck;
            lastWasAck = 1'b0;
            checkOutput("mem_req_start", 32'(bus.mem_req), 32'(expStart));
            checkOutput("ack_quiet", 32'(ackVec), 32'd0);
            if (bus.mem_req && expStart) begin
                winner = pickWinner();
                decisionCount++;
                if (winner == 2) begin
                    if (sndIdx == 0) sndIdx = decisionCount;
                    starve = 0;
                end else if (prevReq[2] && starve < TB_STARVE) begin
                    starve++;
                end
                expAddr = BASES[winner] + 22'(reqAddr[winner]);
                addrLog.push_back(bus.mem_addr);
                checkOutput("mem_addr", 32'(bus.mem_addr), 32'(expAddr));
                inAccess = 1'b1;
                waitCnt  = 1;
                if (forceValid) begin
                    delay      = forceDelay;
                    rdData     = forceData;
                    forceValid = 1'b0;
                end else begin
                    delay  = randomDelay();
                    rdData = 8'($urandom);
                end
            end
        end else if (bus.mem_req) begin
            waitCnt++;
            checkOutput("addr_hold", 32'(bus.mem_addr), 32'(expAddr));
            checkOutput("ack_in_wait", 32'(ackVec), 32'd0);
            if (waitCnt > TB_TIMEOUT) checkOutput("wait_bound", 32'(waitCnt), 32'(TB_TIMEOUT));
        end else begin
            timedOut      = (delay == 0);
            dataM[winner] = timedOut ? 8'hFF : rdData;
            if (timedOut) errM = 1'b1;
            ackLog.push_back(ackVec);
            checkOutput("ack_onehot", 32'(ackVec), 32'd1 << winner);
            checkOutput("wait_len", 32'(waitCnt), 32'(timedOut ? TB_TIMEOUT : delay));
            checkOutput("bg_data", 32'(bus.bg_data), 32'(dataM[0]));
            checkOutput("spr_data", 32'(bus.spr_data), 32'(dataM[1]));
            checkOutput("snd_data", 32'(bus.snd_data), 32'(dataM[2]));
            checkOutput("err", 32'(bus.err), 32'(errM));
            pend[winner] = 1'b0;
            inAccess     = 1'b0;
            lastWasAck   = 1'b1;
        end
        if (inAccess && delay != 0 && waitCnt == delay) begin
            bus.mem_rdy  = 1'b1;
            bus.mem_data = rdData;
        end else begin
            bus.mem_rdy  = 1'b0;
            bus.mem_data = 8'($urandom);
        end
    endtask

    task automatic runCycle();
        @(negedge clk_sys);
        monitorStep();
        applyStimulus();
    endtask

    task automatic runUntilIdle(input int bound, input string tag);
        int n;
        n = 0;
        while ((inAccess || pend[0] || pend[1] || pend[2]) && n < bound) begin
            runCycle();
            n++;
        end
        if (inAccess || pend[0] || pend[1] || pend[2]) checkOutput({"drain_", tag}, 32'(n), 32'(bound + 1));
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_mem_req"}, 32'(bus.mem_req), 32'd0);
        checkOutput({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
        checkOutput({tag, "_acks"}, 32'({bus.snd_ack, bus.spr_ack, bus.bg_ack}), 32'd0);
        checkOutput({tag, "_err"}, 32'(bus.err), 32'd0);
        checkOutput({tag, "_data"}, 32'({bus.bg_data, bus.spr_data, bus.snd_data}), 32'd0);
    endtask

    task automatic resetModel();
        inAccess   = 1'b0;
        lastWasAck = 1'b0;
        starve     = 0;
        errM       = 1'b0;
        forceValid = 1'b0;
        for (int i = 0; i < 3; i++) dataM[i] = 8'h00;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pend[i] = 1'b0; reqAddr[i] = 19'h0; pct[i] = 0;
        end
        bus.mem_rdy = 1'b0; bus.mem_data = 8'h00;
        bus2.bg_req = 1'b0; bus2.spr_req = 1'b0; bus2.snd_req = 1'b0;
        bus2.bg_addr = '0; bus2.spr_addr = '0; bus2.snd_addr = '0;
        bus2.mem_rdy = 1'b0; bus2.mem_data = 8'h00;
        winner = 0; allowLong = 1'b0; decisionCount = 0; sndIdx = 0;
        resetModel();
        driveReqs();

        repeat (3) @(negedge clk_sys);
        checkResetState("reset");
        reset_n = 1'b1;

        $display("[TB] single bg access");
        pend[0] = 1'b1; reqAddr[0] = 19'h00010;
        forceValid = 1'b1; forceDelay = 2; forceData = 8'hA5;
        driveReqs();
        runUntilIdle(40, "single");
        checkOutput("tp_bg_data", 32'(bus.bg_data), 32'h000000A5);

        $display("[TB] simultaneous requests");
        addrLog.delete(); ackLog.delete();
        pend = '{1'b1, 1'b1, 1'b1};
        reqAddr[0] = 19'h12345; reqAddr[1] = 19'h1FFFF; reqAddr[2] = 19'h00001;
        driveReqs();
        runUntilIdle(60, "simul");
        checkOutput("tp_order_count", 32'(ackLog.size()), 32'd3);
        if (ackLog.size() >= 3 && addrLog.size() >= 3) begin
            checkOutput("tp_order_0", 32'(ackLog[0]), 32'd1);
            checkOutput("tp_order_1", 32'(ackLog[1]), 32'd2);
            checkOutput("tp_order_2", 32'(ackLog[2]), 32'd4);
            checkOutput("tp_addr_bg", 32'(addrLog[0]), 32'h012345);
            checkOutput("tp_addr_spr", 32'(addrLog[1]), 32'h09FFFF);
            checkOutput("tp_addr_snd", 32'(addrLog[2]), 32'h0C0001);
        end

        $display("[TB] ready on the timeout cycle");
        pend[0] = 1'b1; reqAddr[0] = 19'h00777;
        forceValid = 1'b1; forceDelay = TB_TIMEOUT; forceData = 8'h3C;
        driveReqs();
        runUntilIdle(100, "rdy_wins");
        checkOutput("tp_rdy_wins_err", 32'(bus.err), 32'd0);
        checkOutput("tp_rdy_wins_data", 32'(bus.bg_data), 32'h3C);

        $display("[TB] starvation");
        pct = '{100, 100, 0};
        pend[0] = 1'b1; reqAddr[0] = 19'h00100;
        pend[1] = 1'b1; reqAddr[1] = 19'h00200;
        for (int round = 0; round < 2; round++) begin
            pend[2] = 1'b1; reqAddr[2] = 19'($urandom) & MASKS[2];
            driveReqs();
            decisionCount = 0; sndIdx = 0;
            n = 0;
            while (pend[2] && n < 400) begin
                runCycle();
                n++;
            end
            checkOutput("tp_starve_decision", 32'(sndIdx), 32'd16);
        end
        pct = '{0, 0, 0};
        runUntilIdle(100, "starve");

        $display("[TB] timeout");
        pend[1] = 1'b1; reqAddr[1] = 19'h00444;
        forceValid = 1'b1; forceDelay = 0; forceData = 8'h00;
        driveReqs();
        runUntilIdle(120, "timeout");
        checkOutput("tp_timeout_data", 32'(bus.spr_data), 32'hFF);
        checkOutput("tp_timeout_err", 32'(bus.err), 32'd1);
        pend = '{1'b1, 1'b0, 1'b1};
        reqAddr[0] = 19'h00011; reqAddr[2] = 19'h00022;
        driveReqs();
        runUntilIdle(40, "after_timeout");
        checkOutput("tp_err_sticky", 32'(bus.err), 32'd1);

        $display("[TB] random traffic");
        allowLong = 1'b1;
        pct = '{25, 25, 25};
        repeat (3000) runCycle();
        pct = '{0, 0, 0};
        runUntilIdle(500, "random");
        allowLong = 1'b0;

        $display("[TB] reset during wait");
        pend[0] = 1'b1; reqAddr[0] = 19'h2AAAA;
        forceValid = 1'b1; forceDelay = 0; forceData = 8'h00;
        driveReqs();
        n = 0;
        while (!(inAccess && waitCnt == 5) && n < 50) begin
            runCycle();
            n++;
        end
        checkOutput("tp_reached_wait", 32'(bus.mem_req), 32'd1);
        reset_n = 1'b0;
        bus.mem_rdy = 1'b0;
        #1;
        checkResetState("mid_reset");
        resetModel();
        @(negedge clk_sys);
        reset_n = 1'b1;
        driveReqs();
        runUntilIdle(40, "post_reset");
        checkOutput("tp_post_reset_data", 32'(bus.bg_data), 32'(dataM[0]));

        $display("[TB] address wrap");
        @(negedge clk_sys);
        bus2.snd_req = 1'b1; bus2.snd_addr = 17'h00020;
        n = 0;
        do begin
            @(negedge clk_sys);
            n++;
        end while (!bus2.mem_req && n < 10);
        checkOutput("tp_wrap_req", 32'(bus2.mem_req), 32'd1);
        checkOutput("tp_wrap_addr", 32'(bus2.mem_addr), 32'h000010);
        bus2.mem_rdy = 1'b1; bus2.mem_data = 8'h5A;
        @(negedge clk_sys);
        bus2.mem_rdy = 1'b0; bus2.snd_req = 1'b0;
        checkOutput("tp_wrap_ack", 32'(bus2.snd_ack), 32'd1);
        checkOutput("tp_wrap_data", 32'(bus2.snd_data), 32'h5A);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
